mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Clrn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port Op  input  6  opcode field of the instruction register.
REQ-005 SHALL have port Zero  input  1  ALU equality flag from the datapath.
REQ-006 SHALL have port imem_ready  input  1  instruction memory data valid.
REQ-007 SHALL have port dmem_ready  input  1  data memory access complete.
REQ-008 SHALL have port PCsrc  output  2  PC mux select: 00 PC+4, 01 branch target, 10 jump target, 11 unused.
REQ-009 SHALL have ports PCWrite, IRWrite, RegWrite, MemRead, MemWrite, RegDst, MemtoReg, ALUSrc, Link, illegal  output  1 each.
REQ-010 SHALL have ports ALUOp  output  2  (00 add, 01 sub, 10 funct-decoded); state  output  3  current state; retired  output  COUNT_W  instructions completed.

Function
REQ-011 SHALL implement a 5-state FSM: FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WBACK=4; codes 5-7 SHALL go to FETCH on the next edge with all outputs 0.
REQ-012 SHALL support opcodes R-type 000000, j 000010, jal 000011, beq 000100, bne 000101, addi 001000, lw 100011, sw 101011; all others are illegal.
REQ-013 SHALL latch Op into an internal op_q only on the clock edge leaving DECODE; EXEC, MEMACC and WBACK SHALL decode from op_q.
REQ-014 FETCH: IRWrite=imem_ready; imem_ready=1 -> DECODE, else stay FETCH with all outputs 0.
REQ-015 DECODE, j: PCWrite=1, PCsrc=10 -> FETCH.
REQ-016 DECODE, jal: PCWrite=1, PCsrc=10, RegWrite=1, Link=1 -> FETCH.
REQ-017 DECODE, illegal: PCWrite=1, PCsrc=00, illegal=1 for exactly that cycle -> FETCH.
REQ-018 DECODE, any other legal opcode -> EXEC with no write strobes.
REQ-019 EXEC, R-type: ALUOp=10, ALUSrc=0 -> WBACK.
REQ-020 EXEC, addi/lw/sw: ALUOp=00, ALUSrc=1; addi -> WBACK, lw/sw -> MEMACC.
REQ-021 EXEC, beq: ALUOp=01, PCWrite=1, PCsrc=(Zero?01:00) -> FETCH.
REQ-022 EXEC, bne: ALUOp=01, PCWrite=1, PCsrc=(Zero?00:01) -> FETCH.
REQ-023 MEMACC, lw: MemRead=1, ALUSrc=1; dmem_ready=1 -> WBACK, else stay.
REQ-024 MEMACC, sw: MemWrite=1, ALUSrc=1; dmem_ready=1 -> also PCWrite=1, PCsrc=00 -> FETCH, else stay.
REQ-025 WBACK: RegWrite=1, PCWrite=1, PCsrc=00; RegDst=1 iff R-type; MemtoReg=1 iff lw -> FETCH.
REQ-026 Outputs not listed for a state/opcode SHALL be 0; PCsrc SHALL be 00 whenever PCWrite=0.
REQ-027 Outputs SHALL be combinational from state, op_q (Op in DECODE), Zero and ready inputs; no output is registered except state and retired.
REQ-028 PCWrite SHALL be 1 for exactly one cycle per instruction, including illegal ones.
REQ-029 retired SHALL increment by 1 on every edge where PCWrite=1 and wrap from 2^COUNT_W-1 to 0.
REQ-030 imem_ready outside FETCH and dmem_ready outside MEMACC SHALL be ignored.
REQ-031 MemRead/MemWrite SHALL be held continuously while waiting in MEMACC.

Reset
REQ-032 Clrn=0 at a rising edge SHALL force state=FETCH, op_q=0, retired=0, regardless of current state, including mid-MEMACC stall.
REQ-033 While Clrn=0, all 1-bit outputs SHALL be 0, PCsrc=00, ALUOp=00.
REQ-034 A pending memory access SHALL be abandoned on reset; first cycle after Clrn rises SHALL be FETCH.

Verification
REQ-035 R-type, imem_ready=1, Op=000000 -> states 0,1,2,4,0; WBACK: RegWrite=1, RegDst=1, PCWrite=1, PCsrc=00; retired 0->1.
REQ-036 lw, dmem_ready low 3 cycles then high -> MEMACC held 4 cycles with MemRead=1; WBACK: MemtoReg=1; 8 cycles total from FETCH.
REQ-037 beq Zero=1 -> EXEC PCsrc=01, PCWrite=1; bne Zero=1 -> PCsrc=00, PCWrite=1; both return to FETCH.
REQ-038 jal -> DECODE: PCsrc=10, Link=1, RegWrite=1, PCWrite=1; Op=111111 -> illegal=1 one cycle, PCsrc=00, retired still +1.
REQ-039 sw stalled in MEMACC, Clrn=0 one edge -> state=0, retired=0, MemWrite=0 same cycle; imem_ready=0 keeps FETCH, IRWrite=0.
REQ-040 COUNT_W=4, 16 j instructions -> retired wraps 15->0.

Source files
------------

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-style control unit.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> MEMACC ->
// WBACK (skipping states the opcode does not need) and drives the datapath
// control strobes combinationally from the current state and opcode.
// A counter of retired instructions advances on every PC write, which
// happens exactly once per instruction (illegal opcodes included).
//
// Ports:
//   Clk         clock, all state updates on the rising edge
//   Clrn        synchronous active-low reset
//   Op[5:0]     opcode field of the instruction register
//   Zero        ALU equality flag (used by beq/bne in EXEC)
//   imem_ready  instruction memory data valid (looked at only in FETCH)
//   dmem_ready  data memory access complete (looked at only in MEMACC)
//   PCsrc[1:0]  PC mux select: 00 PC+4, 01 branch target, 10 jump target
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite, RegDst, MemtoReg,
//   ALUSrc, Link, illegal   single-bit control strobes
//   ALUOp[1:0]  00 add, 01 sub, 10 funct-decoded
//   state[2:0]  current FSM state
//   retired     instructions completed (wraps)
// ---------------------------------------------------------------------------
module mc_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [5:0]         Op,
    input  logic               Zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic [1:0]         PCsrc,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrc,
    output logic               Link,
    output logic               illegal,
    output logic [1:0]         ALUOp,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WBACK  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t               state_q, state_d;
    logic [5:0]           op_q, op_d;
    logic [COUNT_W-1:0]   retired_q, retired_d;

    // Ungated decode results; forced to zero below while reset is asserted.
    logic [1:0] pc_src, alu_op;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write;
    logic       reg_dst, mem_to_reg, alu_src, link, illegal_op;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        link       = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_write = imem_ready;
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // DECODE always exits after one cycle, so capturing here is
                // exactly the edge leaving DECODE.
                op_d = Op;
                case (Op)
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        reg_write = 1'b1;
                        link      = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: begin
                        state_d = S_EXEC;
                    end
                    default: begin
                        // Skip the bad word: advance PC+4 and retire it.
                        pc_write   = 1'b1;
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        alu_op  = 2'b10;
                        state_d = S_WBACK;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        state_d = S_WBACK;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEMACC;
                    end
                    OP_BEQ: begin
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                        pc_src   = Zero ? 2'b01 : 2'b00;
                        state_d  = S_FETCH;
                    end
                    OP_BNE: begin
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                        pc_src   = Zero ? 2'b00 : 2'b01;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEMACC: begin
                // Strobes stay asserted for the whole stall.
                case (op_q)
                    OP_LW: begin
                        mem_read = 1'b1;
                        alu_src  = 1'b1;
                        if (dmem_ready) begin
                            state_d = S_WBACK;
                        end
                    end
                    OP_SW: begin
                        mem_write = 1'b1;
                        alu_src   = 1'b1;
                        if (dmem_ready) begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = (op_q == OP_RTYPE);
                mem_to_reg = (op_q == OP_LW);
                state_d    = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        retired_d = retired_q + COUNT_W'(pc_write);
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q   <= S_FETCH;
            op_q      <= 6'b000000;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // All strobes are held low while reset is asserted, so an in-flight
    // memory access is dropped in the same cycle.
    assign PCsrc    = Clrn ? pc_src     : 2'b00;
    assign ALUOp    = Clrn ? alu_op     : 2'b00;
    assign PCWrite  = Clrn & pc_write;
    assign IRWrite  = Clrn & ir_write;
    assign RegWrite = Clrn & reg_write;
    assign MemRead  = Clrn & mem_read;
    assign MemWrite = Clrn & mem_write;
    assign RegDst   = Clrn & reg_dst;
    assign MemtoReg = Clrn & mem_to_reg;
    assign ALUSrc   = Clrn & alu_src;
    assign Link     = Clrn & link;
    assign illegal  = Clrn & illegal_op;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule
